// File: rtl/dcm_freq_governor.sv
// dcm_freq_governor
//   Closed-loop scheduler for the DCM clock multiplier. Ramps the committed
//   multiplier toward the host target in bounded upward steps with a dwell
//   after every reprogram, drops straight to a safe value on thermal alarm and
//   owns the request handshake towards the DCM reconfiguration programmer.
//   Optional feature macro: DCM_GOV_ERR_BACKOFF_EN enables the hash-error
//   window monitor that lowers the ceiling one step per bad window.
module dcm_freq_governor #(
  parameter int MIN_MULTIPLIER     = 2,
  parameter int MAX_MULTIPLIER     = 88,
  parameter int INITIAL_MULTIPLIER = 60,
  parameter int SAFE_MULTIPLIER    = 20,
  parameter int RAMP_STEP          = 4,
  parameter int DWELL_CYCLES       = 16,
  parameter int ERR_WINDOW         = 1024,
  parameter int ERR_THRESH         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_mult_valid,
  input  logic [7:0] host_mult,
  input  logic       thermal_alarm,
  input  logic       hash_err,
  output logic       prog_req,
  output logic [7:0] prog_mult,
  input  logic       prog_ack,
  input  logic       prog_done,
  output logic [7:0] cur_mult,
  output logic       throttled
);

  localparam logic [7:0] MIN_M  = 8'(MIN_MULTIPLIER);
  localparam logic [7:0] MAX_M  = 8'(MAX_MULTIPLIER);
  localparam logic [7:0] INIT_M = 8'(INITIAL_MULTIPLIER);
  localparam logic [7:0] SAFE_M = 8'(SAFE_MULTIPLIER);
  localparam logic [8:0] RAMP_M = 9'(RAMP_STEP);
  localparam int         DW     = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DWELL = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [7:0]    target_r;
  logic [7:0]    cur_mult_r;
  logic [7:0]    prog_mult_r;
  logic          prog_req_r;
  logic          throttled_r;
  logic [DW-1:0] dwell_cnt_r;
  logic          thermal_d_r;
  logic [7:0]    ceiling_s;
  logic [7:0]    goal_s;
  logic [7:0]    step_s;
  logic [7:0]    next_s;
  logic [8:0]    sum_s;
  logic          therm_rise_s;
  logic          issue_s;
  logic          ack_s;
  logic          commit_s;

  assign prog_req  = prog_req_r;
  assign prog_mult = prog_mult_r;
  assign cur_mult  = cur_mult_r;
  assign throttled = throttled_r;

  assign therm_rise_s = thermal_alarm & ~thermal_d_r;

`ifdef DCM_GOV_ERR_BACKOFF_EN
  localparam int         WW       = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(ERR_WINDOW - 1);
  localparam logic [7:0] THRESH_M = 8'(ERR_THRESH);

  logic [WW-1:0] win_cnt_r;
  logic [7:0]    err_cnt_r;
  logic [7:0]    ceiling_r;
  logic          win_end_s;

  assign win_end_s = (win_cnt_r == WIN_LAST);
  assign ceiling_s = ceiling_r;

  // free-running error sampling window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_r <= '0;
    end else if (win_end_s) begin
      win_cnt_r <= '0;
    end else begin
      win_cnt_r <= win_cnt_r + WW'(1);
    end
  end

  // saturating error count and ceiling backoff; a host write restores the ceiling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'd0;
      ceiling_r <= MAX_M;
    end else if (host_mult_valid) begin
      err_cnt_r <= 8'd0;
      ceiling_r <= MAX_M;
    end else if (win_end_s) begin
      if ((err_cnt_r >= THRESH_M) && (ceiling_r > MIN_M)) begin
        ceiling_r <= ceiling_r - 8'd1;
      end
      // an error on the boundary cycle belongs to the new window
      err_cnt_r <= hash_err ? 8'd1 : 8'd0;
    end else if (hash_err && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end
`else
  localparam int unused_err_cfg = ERR_WINDOW + ERR_THRESH;
  logic unused_hash_err_s;

  assign unused_hash_err_s = hash_err;
  assign ceiling_s         = MAX_M;
`endif

  // goal = min(target, ceiling, thermal cap) and the next multiplier to issue
  always_comb begin
    goal_s = target_r;
    step_s = 8'd0;
    next_s = 8'd0;
    if (ceiling_s < goal_s) begin
      goal_s = ceiling_s;
    end else begin
      goal_s = goal_s;
    end
    if (thermal_alarm && (SAFE_M < goal_s)) begin
      goal_s = SAFE_M;
    end else begin
      goal_s = goal_s;
    end
    // 9-bit sum so the ramp can never wrap past 255
    sum_s = {1'b0, cur_mult_r} + RAMP_M;
    if (goal_s < cur_mult_r) begin
      next_s = goal_s;
    end else begin
      if (sum_s < {1'b0, goal_s}) begin
        step_s = sum_s[7:0];
      end else begin
        step_s = goal_s;
      end
      if (step_s < MIN_M) begin
        next_s = MIN_M;
      end else begin
        next_s = step_s;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decision
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (goal_s != cur_mult_r) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (prog_ack) begin
          // ack and done together: latched and locked in one go
          state_nxt_s = prog_done ? DWELL : BUSY;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      BUSY: begin
        if (prog_done) begin
          state_nxt_s = DWELL;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DWELL: begin
        if (therm_rise_s && (goal_s < cur_mult_r)) begin
          state_nxt_s = IDLE;
        end else if (dwell_cnt_r == '0) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DWELL;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM control strobes for the datapath registers
  always_comb begin
    issue_s  = 1'b0;
    ack_s    = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE:    issue_s  = (goal_s != cur_mult_r);
      ISSUE: begin
        ack_s    = prog_ack;
        commit_s = prog_ack & prog_done;
      end
      BUSY:    commit_s = prog_done;
      DWELL:   issue_s  = 1'b0;
      default: issue_s  = 1'b0;
    endcase
  end

  // programmer request handshake and committed multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_req_r  <= 1'b0;
      prog_mult_r <= 8'd0;
      cur_mult_r  <= 8'd0;
    end else begin
      if (issue_s) begin
        prog_req_r  <= 1'b1;
        prog_mult_r <= next_s;
      end else if (ack_s) begin
        prog_req_r  <= 1'b0;
      end
      if (commit_s) begin
        cur_mult_r <= prog_mult_r;
      end
    end
  end

  // dwell countdown after each commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt_r <= '0;
    end else if (commit_s) begin
      dwell_cnt_r <= DWELL_LOAD;
    end else if ((state_r == DWELL) && (dwell_cnt_r != '0)) begin
      dwell_cnt_r <= dwell_cnt_r - DW'(1);
    end
  end

  // host target capture (clamped), thermal edge history, throttle flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_r    <= INIT_M;
      thermal_d_r <= 1'b0;
      throttled_r <= 1'b0;
    end else begin
      if (host_mult_valid) begin
        if (host_mult < MIN_M) begin
          target_r <= MIN_M;
        end else if (host_mult > MAX_M) begin
          target_r <= MAX_M;
        end else begin
          target_r <= host_mult;
        end
      end
      thermal_d_r <= thermal_alarm;
      throttled_r <= (goal_s < target_r);
    end
  end

endmodule

// File: tb/tb_dcm_freq_governor.sv
// Self-checking bench for dcm_freq_governor: a programmer model serves each
// request and compares it against a queue of expected multipliers.
module tb_dcm_freq_governor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_mult_valid = 1'b0;
  logic [7:0] host_mult = 8'd0;
  logic       thermal_alarm = 1'b0;
  logic       hash_err = 1'b0;
  logic       prog_ack = 1'b0;
  logic       prog_done = 1'b0;
  logic       prog_req;
  logic [7:0] prog_mult;
  logic [7:0] cur_mult;
  logic       throttled;

  int checks = 0;
  int failures = 0;
  int last_wait = 0;
  int cyc = 0;
  logic [7:0] sb[$];

  dcm_freq_governor dut (
    .clk(clk), .rst_n(rst_n), .host_mult_valid(host_mult_valid), .host_mult(host_mult),
    .thermal_alarm(thermal_alarm), .hash_err(hash_err), .prog_req(prog_req),
    .prog_mult(prog_mult), .prog_ack(prog_ack), .prog_done(prog_done),
    .cur_mult(cur_mult), .throttled(throttled)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic host_write(input logic [7:0] v);
    host_mult = v;
    host_mult_valid = 1'b1;
    tick();
    host_mult_valid = 1'b0;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // programmer model: ack 2 cycles after req, done 10 after ack
  task automatic serve(input bit disturb, input bit same_cycle, input bit chk_dwell);
    int n;
    logic [7:0] exp;
    n = 0;
    while (prog_req !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    last_wait = n;
    exp = (sb.size() != 0) ? sb.pop_front() : 8'd0;
    checks++;
    if (prog_req !== 1'b1) begin
      failures++;
      $display("FAIL req_timeout: prog_req=%b required 1 for mult %0d", prog_req, exp);
      return;
    end
    check8("issue_mult", prog_mult, exp);
    if (chk_dwell) begin
      checks++;
      if (n != 17) begin
        failures++;
        $display("FAIL dwell_gap: %0d cycles required 17 before mult %0d", n, exp);
      end
    end
    if (disturb) begin
      host_mult = 8'd10;
      host_mult_valid = 1'b1;
      thermal_alarm = 1'b1;
    end
    tick();
    host_mult_valid = 1'b0;
    check8("hold_mult", prog_mult, exp);
    tick();
    check8("hold_req", {7'd0, prog_req}, 8'd1);
    check8("hold_mult2", prog_mult, exp);
    if (same_cycle) begin
      prog_ack = 1'b1;
      prog_done = 1'b1;
      tick();
      prog_ack = 1'b0;
      prog_done = 1'b0;
    end else begin
      prog_ack = 1'b1;
      tick();
      prog_ack = 1'b0;
      check8("req_drop", {7'd0, prog_req}, 8'd0);
      repeat (9) tick();
      prog_done = 1'b1;
      tick();
      prog_done = 1'b0;
    end
    check8("commit", cur_mult, exp);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    check8("rst_req", {7'd0, prog_req}, 8'd0);
    check8("rst_prog_mult", prog_mult, 8'd0);
    check8("rst_cur", cur_mult, 8'd0);
    check8("rst_throttled", {7'd0, throttled}, 8'd0);
  endtask

  task automatic test_initial_ramp();
    int extra;
    for (int v = 4; v <= 60; v += 4) sb.push_back(8'(v));
    rst_n = 1'b1;
    serve(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) serve(1'b0, 1'b0, 1'b1);
    check8("ramp_final", cur_mult, 8'd60);
    check8("ramp_throttled", {7'd0, throttled}, 8'd0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (prog_req === 1'b1) extra++;
      tick();
    end
    check8("ramp_idle", 8'(extra), 8'd0);
  endtask

  task automatic test_clamp();
    host_write(8'd200);
    for (int v = 64; v <= 88; v += 4) sb.push_back(8'(v));
    serve(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) serve(1'b0, 1'b0, 1'b1);
    check8("clamp_hi", cur_mult, 8'd88);
    host_write(8'd1);
    sb.push_back(8'd2);
    serve(1'b0, 1'b0, 1'b0);
    check8("clamp_lo", cur_mult, 8'd2);
    host_write(8'd88);
    for (int v = 6; v <= 86; v += 4) sb.push_back(8'(v));
    sb.push_back(8'd88);
    serve(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) serve(1'b0, 1'b0, 1'b1);
    check8("reramp", cur_mult, 8'd88);
  endtask

  task automatic test_thermal();
    thermal_alarm = 1'b1;
    sb.push_back(8'd20);
    serve(1'b0, 1'b0, 1'b0);
    check8("therm_escape_wait", 8'(last_wait), 8'd2);
    check8("therm_throttled", {7'd0, throttled}, 8'd1);
    thermal_alarm = 1'b0;
    for (int v = 24; v <= 88; v += 4) sb.push_back(8'(v));
    for (int i = 0; i < 17; i++) serve(1'b0, 1'b0, 1'b1);
    check8("therm_recover", cur_mult, 8'd88);
    check8("therm_unthrottled", {7'd0, throttled}, 8'd0);
  endtask

`ifdef DCM_GOV_ERR_BACKOFF_EN
  task automatic test_err_backoff();
    for (int w = 0; w < 2; w++) begin
      while ((cyc % 1024) < 16 || (cyc % 1024) > 900) tick();
      repeat (5) begin
        hash_err = 1'b1;
        tick();
      end
      hash_err = 1'b0;
      sb.push_back(8'(87 - w));
      serve(1'b0, 1'b0, 1'b0);
      check8("err_throttled", {7'd0, throttled}, 8'd1);
    end
    host_write(8'd88);
    sb.push_back(8'd88);
    serve(1'b0, 1'b0, 1'b0);
    check8("err_restore", {7'd0, throttled}, 8'd0);
  endtask
`endif

  task automatic test_in_flight();
    host_write(8'd40);
    sb.push_back(8'd40);
    serve(1'b1, 1'b0, 1'b0);
    sb.push_back(8'd10);
    serve(1'b0, 1'b0, 1'b1);
    thermal_alarm = 1'b0;
    repeat (2) tick();
    check8("flight_throttled", {7'd0, throttled}, 8'd0);
  endtask

  task automatic test_back_to_back();
    host_write(8'd14);
    sb.push_back(8'd14);
    serve(1'b0, 1'b1, 1'b0);
    repeat (30) tick();
    prog_ack = 1'b1;
    prog_done = 1'b1;
    tick();
    prog_ack = 1'b0;
    prog_done = 1'b0;
    tick();
    check8("stray_cur", cur_mult, 8'd14);
    check8("stray_req", {7'd0, prog_req}, 8'd0);
  endtask

  task automatic test_reset_busy();
    int n;
    host_write(8'd30);
    n = 0;
    while (prog_req !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check8("rb_issue", prog_mult, 8'd18);
    prog_ack = 1'b1;
    tick();
    prog_ack = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check8("rb_req", {7'd0, prog_req}, 8'd0);
    check8("rb_cur", cur_mult, 8'd0);
    check8("rb_prog_mult", prog_mult, 8'd0);
    tick();
    rst_n = 1'b1;
    prog_done = 1'b1;
    tick();
    prog_done = 1'b0;
    check8("rb_late_done", cur_mult, 8'd0);
    sb.push_back(8'd4);
    serve(1'b0, 1'b0, 1'b0);
    check8("rb_restart", cur_mult, 8'd4);
  endtask

  initial begin
    test_reset();
    test_initial_ramp();
    test_clamp();
    test_thermal();
`ifdef DCM_GOV_ERR_BACKOFF_EN
    test_err_backoff();
`endif
    test_in_flight();
    test_back_to_back();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
